// File: rtl/dp_rr_sched.sv
// dp_rr_sched: round-robin arbiter feeding a fixed-latency datapath,
// with an ID tag pipe that routes each result back to its requester.
module dp_rr_sched #(
   parameter int NREQ    = 4,
   parameter int LATENCY = 2,
   parameter int CNTW    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_en,
   input  logic [NREQ-1:0]     i_req,
   input  logic [32*NREQ-1:0]  i_req_data,
   output logic [NREQ-1:0]     o_gnt,
   output logic [31:0]         o_dp_in,
   output logic                o_dp_vld,
   input  logic [31:0]         i_dp_out,
   output logic [NREQ-1:0]     o_rsp_vld,
   output logic [31:0]         o_rsp_data,
   output logic                o_busy,
   output logic [CNTW-1:0]     o_issue_cnt
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW-1:0]              ptr_q, ptr_d;
   logic [IDW-1:0]              gnt_id;
   logic                        gnt_any;
   logic                        dp_vld_q;
   logic [31:0]                 dp_in_q;
   logic [IDW-1:0]              dp_id_q;
   logic [CNTW-1:0]             cnt_q, cnt_d;
   logic [LATENCY-1:0]          tvld_q;
   logic [LATENCY-1:0][IDW-1:0] tid_q;
   logic [NREQ-1:0]             rsp_vld_q, rsp_hot;
   logic [31:0]                 rsp_data_q;

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p,
                                               input int i);
      int s;
      s = int'(p) + i;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   // Search upward from the pointer; the first hit wins.
   always_comb begin
      o_gnt   = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      if (!rst && i_en) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && i_req[wrap_add(ptr_q, i)]) begin
               o_gnt[wrap_add(ptr_q, i)] = 1'b1;
               gnt_id  = wrap_add(ptr_q, i);
               gnt_any = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ptr_d   = gnt_any ? wrap_add(gnt_id, 1) : ptr_q;
      cnt_d   = gnt_any ? cnt_q + CNTW'(1) : cnt_q;
      rsp_hot = '0;
      if (tvld_q[LATENCY-1]) rsp_hot[tid_q[LATENCY-1]] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         dp_vld_q   <= 1'b0;
         dp_in_q    <= '0;
         dp_id_q    <= '0;
         cnt_q      <= '0;
         tvld_q     <= '0;
         tid_q      <= '0;
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         dp_vld_q <= gnt_any;
         if (gnt_any) begin
            dp_in_q <= i_req_data[32*gnt_id +: 32];
            dp_id_q <= gnt_id;
         end
         // Last tag stage lines up with i_dp_out.
         tvld_q[0] <= dp_vld_q;
         tid_q[0]  <= dp_id_q;
         for (int i = 1; i < LATENCY; i++) begin
            tvld_q[i] <= tvld_q[i-1];
            tid_q[i]  <= tid_q[i-1];
         end
         rsp_vld_q <= rsp_hot;
         if (tvld_q[LATENCY-1]) rsp_data_q <= i_dp_out;
      end
   end

   assign o_dp_in     = dp_in_q;
   assign o_dp_vld    = dp_vld_q;
   assign o_rsp_vld   = rsp_vld_q;
   assign o_rsp_data  = rsp_data_q;
   assign o_issue_cnt = cnt_q;
   assign o_busy      = dp_vld_q | (|tvld_q) | (|rsp_vld_q);

endmodule

// File: tb/tb_dp_rr_sched.sv
// Bench for dp_rr_sched: two instances (LATENCY=2/CNTW=16 and
// LATENCY=1/CNTW=4) share stimulus; a transaction model checks each cycle.
module tb_dp_rr_sched;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en  = 1'b0;
   logic [3:0]   req = '0;
   logic [127:0] rdata = '0;

   logic [3:0]  gnt_a, rspv_a, gnt_b, rspv_b;
   logic [31:0] dpin_a, rspd_a, dpin_b, rspd_b;
   logic [31:0] dpout_a = '0, dpout_b = '0;
   logic        dpvld_a, busy_a, dpvld_b, busy_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   dp_rr_sched #(.NREQ(4), .LATENCY(2), .CNTW(16)) u_a (
      .clk(clk), .rst(rst), .i_en(en), .i_req(req), .i_req_data(rdata),
      .o_gnt(gnt_a), .o_dp_in(dpin_a), .o_dp_vld(dpvld_a),
      .i_dp_out(dpout_a), .o_rsp_vld(rspv_a), .o_rsp_data(rspd_a),
      .o_busy(busy_a), .o_issue_cnt(cnt_a));

   dp_rr_sched #(.NREQ(4), .LATENCY(1), .CNTW(4)) u_b (
      .clk(clk), .rst(rst), .i_en(en), .i_req(req), .i_req_data(rdata),
      .o_gnt(gnt_b), .o_dp_in(dpin_b), .o_dp_vld(dpvld_b),
      .i_dp_out(dpout_b), .o_rsp_vld(rspv_b), .o_rsp_data(rspd_b),
      .o_busy(busy_b), .o_issue_cnt(cnt_b));

   function automatic logic [31:0] dpf(input logic [31:0] x);
      return {x[15:0], x[31:16]} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [3:0] oh2id(input logic [3:0] g);
      for (int i = 0; i < 4; i++) if (g[i]) return 4'(i);
      return 4'hF;
   endfunction

   task automatic chk(input string nm, input int n,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got %h want %h", nm, n, act, exp);
      end
   endtask

   // Fake datapath: result = dpf(input), delayed LATENCY cycles.
   logic [31:0] hist_a [3];
   logic [31:0] hist_b [2];
   initial begin
      for (int i = 0; i < 3; i++) hist_a[i] = '0;
      for (int i = 0; i < 2; i++) hist_b[i] = '0;
   end
   always @(negedge clk) begin
      hist_a[2] = hist_a[1];
      hist_a[1] = hist_a[0];
      hist_a[0] = dpf(dpin_a);
      dpout_a   = hist_a[2];
      hist_b[1] = hist_b[0];
      hist_b[0] = dpf(dpin_b);
      dpout_b   = hist_b[1];
   end

   // Output views indexed by instance.
   logic [3:0]  o_g [2];
   logic [3:0]  o_rv [2];
   logic [31:0] o_di [2];
   logic [31:0] o_rd [2];
   logic        o_dv [2];
   logic        o_bz [2];
   logic [31:0] o_ct [2];
   assign o_g[0] = gnt_a;   assign o_g[1] = gnt_b;
   assign o_rv[0] = rspv_a; assign o_rv[1] = rspv_b;
   assign o_di[0] = dpin_a; assign o_di[1] = dpin_b;
   assign o_rd[0] = rspd_a; assign o_rd[1] = rspd_b;
   assign o_dv[0] = dpvld_a; assign o_dv[1] = dpvld_b;
   assign o_bz[0] = busy_a; assign o_bz[1] = busy_b;
   assign o_ct[0] = {16'h0, cnt_a};
   assign o_ct[1] = {28'h0, cnt_b};

   // Transaction model: per instance, rotating pointer, issue count,
   // and a calendar of responses due in future cycles.
   int          m_ptr [2];
   int          m_cnt [2];
   int          m_fly [2];
   logic        m_dv  [2];
   logic [31:0] m_di  [2];
   logic [31:0] m_rd  [2];
   logic        due_v [2][16];
   int          due_id[2][16];
   logic [31:0] due_d [2][16];
   logic [3:0]  eg;
   int          eid, slot, lat;
   logic [31:0] cmask, w;

   always @(negedge clk) begin
      cyc++;
      for (int n = 0; n < 2; n++) begin
         lat   = (n == 0) ? 2 : 1;
         cmask = (n == 0) ? 32'hFFFF : 32'hF;
         slot  = cyc % 16;
         if (rst) begin
            m_ptr[n] = 0; m_cnt[n] = 0; m_fly[n] = 0;
            m_dv[n] = 1'b0; m_di[n] = '0; m_rd[n] = '0;
            for (int s = 0; s < 16; s++) due_v[n][s] = 1'b0;
            chk("rst_gnt", n, 32'(o_g[n]), 0);
            chk("rst_dvld", n, 32'(o_dv[n]), 0);
            chk("rst_rsp", n, 32'(o_rv[n]), 0);
            chk("rst_cnt", n, o_ct[n], 0);
         end else begin
            eg = '0; eid = 0;
            if (en)
               for (int i = 0; i < 4; i++)
                  if (eg == 4'd0 && req[(m_ptr[n] + i) % 4]) begin
                     eid = (m_ptr[n] + i) % 4;
                     eg[eid] = 1'b1;
                  end
            chk("gnt", n, 32'(o_g[n]), 32'(eg));
            chk("dp_vld", n, 32'(o_dv[n]), 32'(m_dv[n]));
            chk("dp_in", n, o_di[n], m_di[n]);
            chk("cnt", n, o_ct[n], 32'(m_cnt[n]) & cmask);
            chk("busy", n, 32'(o_bz[n]), 32'(m_fly[n] > 0));
            if (due_v[n][slot]) begin
               m_rd[n] = due_d[n][slot];
               chk("rsp_vld", n, 32'(o_rv[n]), 32'(1) << due_id[n][slot]);
               due_v[n][slot] = 1'b0;
               m_fly[n]--;
            end else begin
               chk("rsp_vld", n, 32'(o_rv[n]), 0);
            end
            chk("rsp_data", n, o_rd[n], m_rd[n]);
            if (eg != 4'd0) begin
               w = rdata[32*eid +: 32];
               m_dv[n] = 1'b1;
               m_di[n] = w;
               m_ptr[n] = (eid + 1) % 4;
               m_cnt[n]++;
               m_fly[n]++;
               slot = (cyc + 2 + lat) % 16;
               due_v[n][slot]  = 1'b1;
               due_id[n][slot] = eid;
               due_d[n][slot]  = dpf(w);
            end else begin
               m_dv[n] = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; req = '0;
      @(negedge clk);
      tick();
      rst = 1'b0;
   endtask

   logic [31:0] gseq;
   int nr, last, low;

   initial begin
      #1 do_reset();
      // Single request
      en = 1'b1; req = 4'b0001; rdata[31:0] = 32'hA5;
      @(negedge clk);
      chk("t1_gnt", 0, 32'(gnt_a), 32'h1);
      chk("t1_cnt0", 0, 32'(cnt_a), 0);
      tick(); req = '0;
      @(negedge clk);
      chk("t1_dvld", 0, 32'(dpvld_a), 1);
      chk("t1_dpin", 0, dpin_a, 32'hA5);
      chk("t1_cnt1", 0, 32'(cnt_a), 1);
      @(negedge clk);
      chk("t1_rspb_early", 1, 32'(rspv_b), 0);
      @(negedge clk);
      chk("t1_rspb", 1, 32'(rspv_b), 32'h1);
      chk("t1_rspdb", 1, rspd_b, 32'h5AFF_0000);
      chk("t1_rspa_early", 0, 32'(rspv_a), 0);
      @(negedge clk);
      chk("t1_rspa", 0, 32'(rspv_a), 32'h1);
      chk("t1_rspda", 0, rspd_a, 32'h5AFF_0000);
      @(negedge clk);
      chk("t1_idle", 0, 32'(busy_a), 0);
      tick();

      // All four requesting
      do_reset();
      rdata = {32'h13, 32'h12, 32'h11, 32'h10};
      en = 1'b1; req = 4'hF; gseq = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         gseq = {gseq[27:0], oh2id(gnt_a)};
         tick();
      end
      req = '0;
      chk("t2_order", 0, gseq, 32'h0123_0123);
      repeat (6) tick();
      chk("t2_cnt", 0, 32'(cnt_a), 8);
      chk("t2_cntb", 1, 32'(cnt_b), 8);

      // Fairness between 0 and 2
      do_reset();
      en = 1'b1; req = 4'b0101; gseq = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         gseq = {gseq[27:0], oh2id(gnt_a)};
         tick();
      end
      req = '0;
      chk("t3_order", 0, gseq, 32'h0002_0202);
      repeat (6) tick();

      // Drain on i_en low with two words in flight
      do_reset();
      en = 1'b1; req = 4'hF;
      @(negedge clk); tick();
      @(negedge clk); tick();
      en = 1'b0;
      nr = 0; last = -1; low = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) chk("t4_gnt_off", 0, 32'(gnt_a), 0);
         if (rspv_a != 4'd0) begin nr++; last = i; end
         if (!busy_a && low < 0) low = i;
      end
      chk("t4_nrsp", 0, nr, 2);
      chk("t4_last", 0, last, 3);
      chk("t4_busy_fall", 0, low, last + 1);
      tick(); req = '0;

      // Async reset with words in flight
      do_reset();
      en = 1'b1; req = 4'hF;
      @(negedge clk); tick();
      @(negedge clk); tick();
      rst = 1'b1;
      #1;
      chk("t5_dvld", 0, 32'(dpvld_a), 0);
      chk("t5_gnt", 0, 32'(gnt_a), 0);
      chk("t5_cnt", 0, 32'(cnt_a), 0);
      chk("t5_busy", 0, 32'(busy_a), 0);
      chk("t5_dpin", 0, dpin_a, 0);
      @(negedge clk); tick();
      rst = 1'b0; req = '0; nr = 0;
      repeat (6) begin
         @(negedge clk);
         if (rspv_a != 4'd0) nr++;
         if (rspv_b != 4'd0) nr++;
      end
      chk("t5_no_rsp", 0, nr, 0);
      tick(); req = 4'hF;
      @(negedge clk);
      chk("t5_gnt0", 0, 32'(gnt_a), 32'h1);
      tick(); req = '0;

      // Counter wrap with a lone requester
      do_reset();
      en = 1'b1; req = 4'b0001; rdata[31:0] = 32'h7;
      repeat (17) tick();
      req = '0;
      @(negedge clk);
      chk("t6_wrap", 1, 32'(cnt_b), 1);
      chk("t6_cnt", 0, 32'(cnt_a), 17);
      repeat (6) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
